dm_port_sched: RTL and testbench
================================

# dm_port_sched

Schedules the single-port 1024-word data memory between the pipeline MEM stage (CPU port) and a burst DMA engine. Accepts DMA burst descriptors, sequences one word per granted cycle with auto-incrementing addresses, and arbitrates word-by-word against CPU accesses using round-robin. Drives the data memory's `din`/`daddr`/`pc`/`memwrite`, which writes on the rising clock edge and reads asynchronously. Sits between the MEM stage, the DMA source/sink, and the data memory.

## Interface
- `ADDR_W`, 10, word-index width; DEPTH = 2^ADDR_W.
- `LEN_W`, 11, burst length field width (0..2^ADDR_W).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: MEM-stage access request, combinational from the stage.
- `cpu_we` in 1: CPU store.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_pc` in 32: PC of the access, forwarded for the memory's write log.
- `cpu_gnt` out 1: CPU access performed this cycle.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`.
- `cpu_rdata` out 32: read data, valid when `cpu_gnt`.
- `dma_start` in 1: one-cycle descriptor strobe.
- `dma_we` in 1: burst direction (1 = write to memory).
- `dma_base` in ADDR_W: first word index.
- `dma_len` in LEN_W: number of words.
- `dma_wdata` in 32: current beat's write data; held until `dma_beat`.
- `dma_beat` out 1: current beat performed this cycle.
- `dma_rdata` out 32: read data, valid when `dma_beat`.
- `dma_busy` out 1: burst in progress.
- `dma_done` out 1: one-cycle completion pulse.
- `dm_din` out 32: to memory.
- `dm_daddr` out 32: to memory.
- `dm_pc` out 32: to memory.
- `dm_memwrite` out 1: to memory.
- `dm_dout` in 32: from memory, asynchronous read.

## Operation
- **FSM states:** IDLE, BURST, DONE.
  - IDLE/DONE + `dma_start`: latch `dma_base`, `dma_len`, `dma_we`; clear the beat counter. Go to BURST, or to DONE if len = 0.
  - BURST: on the last `dma_beat` (count = len−1), go to DONE.
  - DONE: assert `dma_done` for one cycle. Go to IDLE, unless `dma_start` (handled as in IDLE).
- `dma_start` in BURST is ignored: no latch, no error.
- **DMA request:** internal request = (state == BURST).
- **Round-robin:** one priority bit `prio` (0 = CPU first); reset value 0.
  - Only one requester: it is granted.
  - Both requesting: grant the `prio` side.
  - Any grant sets `prio` to the other side.
  - With no grant, `prio` holds.
- **Memory drive:**
  - CPU granted: `dm_daddr` = `cpu_addr`, `dm_din` = `cpu_wdata`, `dm_pc` = `cpu_pc`, `dm_memwrite` = `cpu_we`.
  - DMA granted: `dm_daddr` = {20'b0, (base+count) mod DEPTH, 2'b00}, `dm_din` = `dma_wdata`, `dm_pc` = 0, `dm_memwrite` = `dma_we`.
  - No grant: `dm_memwrite` = 0, `dm_daddr`/`dm_din`/`dm_pc` = 0.
- **Read data:** `cpu_rdata` and `dma_rdata` both = `dm_dout`, each qualified by its grant.
- **Address arithmetic:** the word address wraps modulo DEPTH (base 1023 + 1 → 0). CPU address bits above [ADDR_W+1:2] and [1:0] pass through unchanged.

## Timing
- **Grants:** combinational in the same cycle as the request. Store takes effect at the end of the granted cycle. Zero-cycle read latency.
- **Beat counter:** increments at the clock edge ending a `dma_beat` cycle.
- **`dma_busy`:** high from the cycle after an accepted start (len ≥ 1) through the last-beat cycle. Low in DONE.
- **`dma_done`:** exactly one cycle after the last beat. For len = 0, the cycle after start.
- **Simultaneous events:** contested cycles alternate strictly, so each side's worst-case wait is 1 cycle.
- **Reset values (during and after a reset cycle):**
  - state IDLE, `prio` = 0, counter = 0.
  - `cpu_gnt`, `cpu_stall`, `dma_beat`, `dma_busy`, `dma_done`, `dm_memwrite` = 0.
  - all data/address outputs = 0.
  - `cpu_req` and `dma_start` are ignored while `reset` = 1.
- **Reset mid-burst:** the burst is aborted, with no `dma_done` and no further beats.

## Structure
- **Shared package:** FSM state encoding (IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2) and DM_WORDS = 1024.
- **Sub-module `rr_arb2`:** 2-way round-robin arbiter holding the `prio` register. Inputs: `clk`, `reset`, `req[1:0]`. Output: one-hot `gnt[1:0]`.
- The burst sequencer and the memory mux remain in the top module.

## Test plan
1. **Solo CPU:** CPU stores 0xDEADBEEF to 0x0000_0010, no DMA; then loads 0x10 next cycle → `cpu_gnt` both cycles, `cpu_stall` = 0, `cpu_rdata` = 0xDEADBEEF.
2. **DMA write burst:** base 1022, len 4, data 1,2,3,4, CPU idle → beats in 4 consecutive cycles to word indices 1022, 1023, 0, 1 (wrap). `dma_done` in cycle 5, `dma_busy` low there.
3. **Contention:** CPU requests every cycle during a DMA len-3 read burst → grants C, D, C, D, C, D. `cpu_stall` high on the D cycles. Burst completes in 6 cycles.
4. **Edge cases:** `dma_start` with len = 0 → no beat, `dma_done` the next cycle. `dma_start` during BURST → ignored; the original burst's addresses and length are unchanged.
5. **Reset mid-burst:** `reset` on beat 2 of a len-8 burst → next cycle `dma_busy` = 0, no `dma_done`, no writes after beat 1. `prio` = 0, so the CPU wins the first contested cycle.
6. **Back-to-back bursts:** `dma_start` asserted in the DONE cycle → new burst accepted; `dma_busy` high the following cycle.

Source files
------------

// File: rtl/dm_port_sched_pkg.sv
// Shared definitions for the data-memory port scheduler.
package dm_port_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } dm_state_e;

  localparam int DM_WORDS = 1024;

endpackage

// File: rtl/dm_port_sched_if.sv
// Bundle of CPU, DMA and data-memory signals around the port scheduler.
interface dm_port_sched_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);

  // CPU (MEM stage) side
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_pc;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;

  // DMA side
  logic              dma_start;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_base;
  logic [LEN_W-1:0]  dma_len;
  logic [31:0]       dma_wdata;
  logic              dma_beat;
  logic [31:0]       dma_rdata;
  logic              dma_busy;
  logic              dma_done;

  // Data memory side
  logic [31:0]       dm_din;
  logic [31:0]       dm_daddr;
  logic [31:0]       dm_pc;
  logic              dm_memwrite;
  logic [31:0]       dm_dout;

  // Scheduler view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    output cpu_gnt, cpu_stall, cpu_rdata,
    input  dma_start, dma_we, dma_base, dma_len, dma_wdata,
    output dma_beat, dma_rdata, dma_busy, dma_done,
    output dm_din, dm_daddr, dm_pc, dm_memwrite,
    input  dm_dout
  );

  // Environment view (MEM stage, DMA engine, memory)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    output dma_start, dma_we, dma_base, dma_len, dma_wdata,
    input  dma_beat, dma_rdata, dma_busy, dma_done,
    input  dm_din, dm_daddr, dm_pc, dm_memwrite,
    output dm_dout
  );

endinterface

// File: rtl/dm_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; req[0] = CPU, req[1] = DMA.
// prio 0 favours the CPU; every grant hands priority to the other side.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  // Grant selection and priority update
  always_comb begin
    gnt    = req;
    prio_d = prio_q;
    if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  // Priority register
  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/dm_port_sched.sv
// Data-memory port scheduler: DMA burst sequencer plus word-by-word
// round-robin sharing of the single memory port with the CPU.
module dm_port_sched
  import dm_port_sched_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic           clk,
  input  logic           reset,
  dm_port_sched_if.slave bus
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        req, gnt;
  logic              cpu_gnt, dma_gnt;
  logic [ADDR_W-1:0] word_addr;

  // Requests are masked during reset so nothing is granted in that cycle
  assign req     = {(state_q == ST_BURST), bus.cpu_req} & {2{~reset}};
  assign cpu_gnt = gnt[0];
  assign dma_gnt = gnt[1];

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  // Current beat's word index, wrapping modulo the memory depth
  assign word_addr = base_q + cnt_q[ADDR_W-1:0];

  // Burst sequencer next-state
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.dma_start) begin
          base_d  = bus.dma_base;
          len_d   = bus.dma_len;
          we_d    = bus.dma_we;
          cnt_d   = '0;
          state_d = (bus.dma_len == '0) ? ST_DONE : ST_BURST;
        end
      end
      ST_BURST: begin
        // A new start here is deliberately ignored
        if (dma_gnt) begin
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any burst without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory port mux and qualified read data
  always_comb begin
    bus.dm_daddr    = '0;
    bus.dm_din      = '0;
    bus.dm_pc       = '0;
    bus.dm_memwrite = 1'b0;
    if (cpu_gnt) begin
      bus.dm_daddr    = bus.cpu_addr;
      bus.dm_din      = bus.cpu_wdata;
      bus.dm_pc       = bus.cpu_pc;
      bus.dm_memwrite = bus.cpu_we;
    end else if (dma_gnt) begin
      bus.dm_daddr    = {{(30-ADDR_W){1'b0}}, word_addr, 2'b00};
      bus.dm_din      = bus.dma_wdata;
      bus.dm_memwrite = we_q;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.cpu_stall = req[0] & ~cpu_gnt;
  assign bus.cpu_rdata = cpu_gnt ? bus.dm_dout : '0;
  assign bus.dma_beat  = dma_gnt;
  assign bus.dma_rdata = dma_gnt ? bus.dm_dout : '0;
  assign bus.dma_busy  = ~reset & (state_q == ST_BURST);
  assign bus.dma_done  = ~reset & (state_q == ST_DONE);

endmodule

// File: tb/tb_dm_port_sched.sv
// Bench for dm_port_sched: directed stimulus, a per-cycle reference model
// of the port sharing, and literal checks of the planned scenarios.
module tb_dm_port_sched;
  import dm_port_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  int   n_checks = 0;
  int   n_errors = 0;

  dm_port_sched_if #(.ADDR_W(10), .LEN_W(11)) bus ();

  dm_port_sched #(.ADDR_W(10), .LEN_W(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, asynchronous read
  logic [31:0] tbmem [DM_WORDS];
  assign bus.dm_dout = tbmem[bus.dm_daddr[11:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DM_WORDS; i++) tbmem[i] <= '0;
    end else if (bus.dm_memwrite) begin
      tbmem[bus.dm_daddr[11:2]] <= bus.dm_din;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words left in the burst, next word, priority side
  int          m_left = 0;
  logic [9:0]  m_addr = '0;
  logic        m_we   = 1'b0;
  logic        m_prio = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] mmem [DM_WORDS];

  always @(negedge clk) begin
    logic dreq, creq, cwin, dwin, nd;
    logic [31:0] e_addr, e_din, e_pc, e_rc, e_rd;
    logic e_mw;
    if (mem_clr) for (int i = 0; i < DM_WORDS; i++) mmem[i] = '0;
    if (reset) begin
      chk("rst_cpu_gnt", bus.cpu_gnt, 0);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_beat", bus.dma_beat, 0);
      chk("rst_busy", bus.dma_busy, 0);
      chk("rst_done", bus.dma_done, 0);
      chk("rst_memwrite", bus.dm_memwrite, 0);
      chk("rst_daddr", bus.dm_daddr, 0);
      chk("rst_din", bus.dm_din, 0);
      chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
      m_left = 0; m_done = 1'b0; m_prio = 1'b0;
    end else begin
      dreq = (m_left > 0);
      creq = bus.cpu_req;
      cwin = creq && (!dreq || !m_prio);
      dwin = dreq && (!creq || m_prio);
      e_addr = cwin ? bus.cpu_addr : dwin ? {20'b0, m_addr, 2'b00} : 32'h0;
      e_din  = cwin ? bus.cpu_wdata : dwin ? bus.dma_wdata : 32'h0;
      e_pc   = cwin ? bus.cpu_pc : 32'h0;
      e_mw   = cwin ? bus.cpu_we : dwin ? m_we : 1'b0;
      e_rc   = cwin ? mmem[bus.cpu_addr[11:2]] : 32'h0;
      e_rd   = dwin ? mmem[m_addr] : 32'h0;
      chk("cpu_gnt", bus.cpu_gnt, cwin);
      chk("cpu_stall", bus.cpu_stall, creq && !cwin);
      chk("dma_beat", bus.dma_beat, dwin);
      chk("dma_busy", bus.dma_busy, dreq);
      chk("dma_done", bus.dma_done, m_done);
      chk("dm_daddr", bus.dm_daddr, e_addr);
      chk("dm_din", bus.dm_din, e_din);
      chk("dm_pc", bus.dm_pc, e_pc);
      chk("dm_memwrite", bus.dm_memwrite, e_mw);
      chk("cpu_rdata", bus.cpu_rdata, e_rc);
      chk("dma_rdata", bus.dma_rdata, e_rd);
      if (cwin) m_prio = 1'b1;
      else if (dwin) m_prio = 1'b0;
      if (cwin && bus.cpu_we) mmem[bus.cpu_addr[11:2]] = bus.cpu_wdata;
      if (dwin && m_we) mmem[m_addr] = bus.dma_wdata;
      nd = 1'b0;
      if (dwin) begin
        m_addr = m_addr + 10'd1;
        m_left = m_left - 1;
        if (m_left == 0) nd = 1'b1;
      end
      if (!dreq && bus.dma_start) begin
        m_left = int'(bus.dma_len);
        m_addr = bus.dma_base;
        m_we   = bus.dma_we;
        if (bus.dma_len == 0) nd = 1'b1;
      end
      m_done = nd;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); #1; endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] seq;
    logic [9:0]  w2 [4];
    w2[0] = 10'd1022; w2[1] = 10'd1023; w2[2] = 10'd0; w2[3] = 10'd1;
    reset = 1'b1; mem_clr = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20;
    bus.cpu_wdata = 32'h1234; bus.cpu_pc = 32'h0;
    bus.dma_start = 1'b1; bus.dma_we = 1'b1; bus.dma_base = 10'd5;
    bus.dma_len = 11'd5; bus.dma_wdata = 32'h0;
    // Requests and starts are ignored during reset
    smp; chk("lit_rst_gnt", bus.cpu_gnt, 0); chk("lit_rst_mw", bus.dm_memwrite, 0);
    tick; mem_clr = 1'b0;
    tick; reset = 1'b0; bus.cpu_req = 1'b0; bus.dma_start = 1'b0;
    smp; chk("lit_after_rst_busy", bus.dma_busy, 0); chk("lit_after_rst_done", bus.dma_done, 0);

    // Solo CPU store then load
    tick; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10;
    bus.cpu_wdata = 32'hDEADBEEF; bus.cpu_pc = 32'h40;
    smp; chk("lit_st_gnt", bus.cpu_gnt, 1); chk("lit_st_daddr", bus.dm_daddr, 32'h10);
    tick; bus.cpu_we = 1'b0;
    smp; chk("lit_ld_rdata", bus.cpu_rdata, 32'hDEADBEEF); chk("lit_ld_stall", bus.cpu_stall, 0);

    // DMA write burst wrapping past the top of memory
    tick; bus.cpu_req = 1'b0; bus.dma_start = 1'b1; bus.dma_we = 1'b1;
    bus.dma_base = 10'd1022; bus.dma_len = 11'd4; bus.dma_wdata = 32'd1;
    tick; bus.dma_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp; chk("lit_wr_beat", bus.dma_beat, 1);
      chk("lit_wr_addr", bus.dm_daddr, {20'b0, w2[i], 2'b00});
      tick; bus.dma_wdata = 32'(i + 2);
    end
    smp; chk("lit_wr_done", bus.dma_done, 1); chk("lit_wr_busy", bus.dma_busy, 0);
    chk("lit_mem1022", tbmem[1022], 1); chk("lit_mem1023", tbmem[1023], 2);
    chk("lit_mem0", tbmem[0], 3); chk("lit_mem1", tbmem[1], 4);

    // Contention: CPU every cycle during a len-3 read burst
    tick; bus.dma_start = 1'b1; bus.dma_we = 1'b0; bus.dma_base = 10'd4; bus.dma_len = 11'd3;
    tick; bus.dma_start = 1'b0; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h14;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      smp;
      seq = {seq[39:0], bus.cpu_gnt ? 8'h43 : (bus.dma_beat ? 8'h44 : 8'h2D)};
      chk("lit_ct_stall", bus.cpu_stall, bus.dma_beat);
      if (i == 1) chk("lit_ct_rdata", bus.dma_rdata, 32'hDEADBEEF);
      tick;
    end
    bus.cpu_req = 1'b0;
    chk("lit_ct_order", {16'h0, seq}, 64'h0000_4344_4344_4344);
    smp; chk("lit_ct_done", bus.dma_done, 1);

    // Zero-length burst
    tick; bus.dma_start = 1'b1; bus.dma_len = 11'd0; bus.dma_base = 10'd7; bus.dma_we = 1'b1;
    smp; chk("lit_z_beat", bus.dma_beat, 0);
    tick; bus.dma_start = 1'b0;
    smp; chk("lit_z_done", bus.dma_done, 1); chk("lit_z_mw", bus.dm_memwrite, 0);

    // Start during a burst is ignored
    tick; bus.dma_start = 1'b1; bus.dma_base = 10'd100; bus.dma_len = 11'd3;
    bus.dma_we = 1'b1; bus.dma_wdata = 32'hA0;
    tick; bus.dma_base = 10'd500; bus.dma_len = 11'd9;
    for (int i = 0; i < 3; i++) begin
      smp; chk("lit_ig_addr", bus.dm_daddr, 32'((100 + i) * 4)); chk("lit_ig_beat", bus.dma_beat, 1);
      tick; bus.dma_start = 1'b0; bus.dma_wdata = 32'(32'hA1 + i);
    end
    smp; chk("lit_ig_done", bus.dma_done, 1);
    chk("lit_ig_m500", tbmem[500], 0); chk("lit_ig_m102", tbmem[102], 32'hA2);

    // Reset mid-burst: beat 1 writes, beat 2 is cut by reset
    tick; bus.dma_start = 1'b1; bus.dma_base = 10'd200; bus.dma_len = 11'd8;
    bus.dma_we = 1'b1; bus.dma_wdata = 32'h50;
    tick; bus.dma_start = 1'b0;
    smp; chk("lit_rb_beat1", bus.dma_beat, 1);
    tick; bus.dma_wdata = 32'h51; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0;
    smp; chk("lit_rb_cpu", bus.cpu_gnt, 1);
    tick; reset = 1'b1;
    smp; chk("lit_rb_mw", bus.dm_memwrite, 0); chk("lit_rb_beat2", bus.dma_beat, 0);
    tick; reset = 1'b0; bus.cpu_req = 1'b0; bus.dma_start = 1'b1;
    bus.dma_base = 10'd300; bus.dma_len = 11'd2; bus.dma_we = 1'b0;
    smp; chk("lit_rb_busy", bus.dma_busy, 0); chk("lit_rb_done", bus.dma_done, 0);
    tick; bus.dma_start = 1'b0; bus.cpu_req = 1'b1;
    smp; chk("lit_rb_prio", bus.cpu_gnt, 1);
    tick; bus.cpu_req = 1'b0;
    smp; chk("lit_rb_b0", bus.dma_beat, 1);
    tick;
    smp; chk("lit_rb_b1", bus.dma_beat, 1);

    // Back-to-back: new start in the done cycle
    tick; bus.dma_start = 1'b1; bus.dma_base = 10'd1020; bus.dma_len = 11'd2;
    bus.dma_we = 1'b1; bus.dma_wdata = 32'h77;
    smp; chk("lit_bb_done", bus.dma_done, 1);
    tick; bus.dma_start = 1'b0;
    smp; chk("lit_bb_busy", bus.dma_busy, 1); chk("lit_bb_addr", bus.dm_daddr, 32'hFF0);
    tick; bus.dma_wdata = 32'h78;
    smp; chk("lit_bb_addr2", bus.dm_daddr, 32'hFF4);
    tick;
    smp; chk("lit_bb_done2", bus.dma_done, 1);
    chk("lit_rb_m200", tbmem[200], 32'h50); chk("lit_rb_m201", tbmem[201], 0);
    chk("lit_bb_m1021", tbmem[1021], 32'h78);
    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
